// File: rtl/rename_pkg.sv
// Shared rename-stage constants and types for the physical-register free list.
package rename_pkg;
  localparam int PREG       = 6;
  localparam int NUM_PREG   = 64;
  localparam int NUM_AREG   = 32;
  localparam int DECODE_NUM = 4;
  localparam int RETIRE_NUM = 4;
  localparam int FL_DEPTH   = NUM_PREG - NUM_AREG;
  localparam int PTR_W      = $clog2(FL_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  typedef logic [PREG-1:0]  preg_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/free_list_if.sv
// Rename allocation and commit release signals between the pipeline and the free list.
interface free_list_if;
  import rename_pkg::*;

  logic [DECODE_NUM-1:0]      alloc_req;
  logic                       alloc_ready;
  logic [DECODE_NUM*PREG-1:0] alloc_preg;
  logic [RETIRE_NUM-1:0]      retire;
  logic [RETIRE_NUM-1:0]      rob_areg_v;
  logic [RETIRE_NUM*PREG-1:0] rob_opreg;
  logic [CNT_W-1:0]           free_count;
  logic                       overflow_err;

  modport master (
    output alloc_req, retire, rob_areg_v, rob_opreg,
    input  alloc_ready, alloc_preg, free_count, overflow_err
  );

  modport slave (
    input  alloc_req, retire, rob_areg_v, rob_opreg,
    output alloc_ready, alloc_preg, free_count, overflow_err
  );
endinterface

// File: rtl/prefix_cnt4.sv
// 4-bit exclusive prefix popcount: prefix_o[i] = ones in vec_i[i-1:0], total_o = ones in vec_i.
module prefix_cnt4 (
  input  logic [3:0]      vec_i,
  output logic [3:0][2:0] prefix_o,
  output logic [2:0]      total_o
);
  logic [2:0] acc;

  always_comb begin
    acc      = '0;
    prefix_o = '0;
    for (int i = 0; i < 4; i++) begin
      prefix_o[i] = acc;
      acc         = acc + {2'b00, vec_i[i]};
    end
    total_o = acc;
  end
endmodule

// File: rtl/free_list.sv
// Circular FIFO of free physical registers: up to 4 allocations and 4 releases per cycle,
// allocation is all-or-nothing and sees only start-of-cycle state.
module free_list
  import rename_pkg::*;
(
  input logic        clk,
  input logic        rst,
  free_list_if.slave fl_if
);
  preg_t fl_q [FL_DEPTH];
  preg_t fl_d [FL_DEPTH];
  ptr_t  head_q, head_d;
  ptr_t  tail_q, tail_d;
  cnt_t  count_q, count_d;
  logic  ovf_q, ovf_d;

  logic [3:0][2:0]       a_prefix, r_prefix;
  logic [2:0]            n_alloc, n_rel;
  logic [RETIRE_NUM-1:0] rel;
  logic                  alloc_ready;
  cnt_t                  alloc_amt, cnt_after_alloc, room, rel_amt;
  logic                  rel_over;
  ptr_t                  wr_addr [RETIRE_NUM];
  logic [RETIRE_NUM-1:0] wr_en;

  assign rel = fl_if.retire & fl_if.rob_areg_v;

  prefix_cnt4 u_alloc_cnt (
    .vec_i    (fl_if.alloc_req),
    .prefix_o (a_prefix),
    .total_o  (n_alloc)
  );

  prefix_cnt4 u_rel_cnt (
    .vec_i    (rel),
    .prefix_o (r_prefix),
    .total_o  (n_rel)
  );

  assign alloc_ready     = count_q >= cnt_t'(n_alloc);
  assign alloc_amt       = alloc_ready ? cnt_t'(n_alloc) : '0;
  assign cnt_after_alloc = count_q - alloc_amt;
  // Releases beyond the remaining room are illegal; keep the earliest slots, drop the rest.
  assign room            = cnt_t'(FL_DEPTH) - cnt_after_alloc;
  assign rel_over        = cnt_t'(n_rel) > room;
  assign rel_amt         = rel_over ? room : cnt_t'(n_rel);

  generate
    for (genvar gi = 0; gi < DECODE_NUM; gi++) begin : g_alloc
      ptr_t rd_addr;
      assign rd_addr = head_q + ptr_t'(a_prefix[gi]);
      assign fl_if.alloc_preg[gi*PREG +: PREG] = fl_if.alloc_req[gi] ? fl_q[rd_addr] : '0;
    end

    for (genvar gi = 0; gi < RETIRE_NUM; gi++) begin : g_rel
      assign wr_addr[gi] = tail_q + ptr_t'(r_prefix[gi]);
      assign wr_en[gi]   = rel[gi] && (cnt_t'(r_prefix[gi]) < rel_amt);
    end
  endgenerate

  always_comb begin
    fl_d = fl_q;
    for (int j = 0; j < RETIRE_NUM; j++) begin
      if (wr_en[j]) begin
        fl_d[wr_addr[j]] = fl_if.rob_opreg[j*PREG +: PREG];
      end
    end
    head_d  = head_q + ptr_t'(alloc_amt);
    tail_d  = tail_q + ptr_t'(rel_amt);
    count_d = cnt_after_alloc + rel_amt;
    ovf_d   = ovf_q | rel_over;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        fl_q[i] <= preg_t'(NUM_AREG + i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= cnt_t'(FL_DEPTH);
      ovf_q   <= 1'b0;
    end else begin
      fl_q    <= fl_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign fl_if.alloc_ready  = alloc_ready;
  assign fl_if.free_count   = count_q;
  assign fl_if.overflow_err = ovf_q;
endmodule
